// File: rtl/tiny_alu_ctrl_p.sv
// tiny_alu_ctrl_p: fixed-latency TinyALU core with ALU ops, windowed memory and supervisor query.
// Outputs update and done pulses on the edge that leaves DONE, so done lands three edges after start.
module tiny_alu_ctrl_p #(
    parameter int DW = 32,
    parameter int MEM_DEPTH = 256,
    parameter logic [2*DW-1:0] SV_MAGIC = 'hDEADBEEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic [7:0]      op,
    input  logic            op_pf,
    input  logic            sv,
    input  logic            start,
    output logic            done,
    output logic [2*DW-1:0] result,
    output logic [5:0]      err,
    output logic            gp
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_FIN} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   a_q, b_q;
    logic [7:0]      op_q;
    logic            pf_q, sv_q, busy_q, we_q, busy_now, wr_ok, lo, hi;
    logic [2*DW-1:0] res_q, r;
    logic [5:1]      err_q, e;
    logic [AW:0]     idx;
    logic [DW:0]     sum;
    logic [DW-1:0]   mem [2*MEM_DEPTH];
    logic [2*MEM_DEPTH-1:0] vld;

    // Low window occupies indices [0,MEM_DEPTH), high window the upper half.
    assign lo       = a_q[DW-1:AW] == '0;
    assign hi       = &a_q[DW-1:AW];
    assign idx      = {hi, a_q[AW-1:0]};
    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign busy_now = busy_q | start;
    assign wr_ok    = state == S_FIN && we_q && err_q == '0 && !busy_now;
    assign gp       = |err;

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:   state_nx = start ? S_DECODE : S_IDLE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = S_FIN;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        r = '0;
        e = '0;
        if (!pf_q) begin
            case (op_q)
                8'h00: r = {{(DW-1){1'b0}}, sum};
                8'h01: r = {{(DW-1){1'b0}}, a_q < b_q, a_q - b_q};
                8'h02: r = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
                8'h03: r = {{DW{1'b0}}, a_q & b_q};
                8'h04: r = {{DW{1'b0}}, a_q | b_q};
                8'h05: r = {{DW{1'b0}}, a_q ^ b_q};
                8'h0A: begin
                    r    = SV_MAGIC;
                    e[1] = !sv_q;
                end
                default: e[2] = 1'b1;
            endcase
        end else begin
            case (op_q)
                8'h00: begin
                    e[4] = !(lo || hi);
                    e[1] = hi && !sv_q;
                    e[3] = (lo || (hi && sv_q)) && !vld[idx];
                    r    = {{DW{1'b0}}, mem[idx]};
                end
                8'h01: begin
                    e[5] = !(lo || hi);
                    e[1] = hi && !sv_q;
                    r    = {{DW{1'b0}}, b_q};
                end
                default: e[2] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done   <= 1'b0;
            result <= '0;
            err    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            pf_q   <= 1'b0;
            sv_q   <= 1'b0;
            busy_q <= 1'b0;
            we_q   <= 1'b0;
            res_q  <= '0;
            err_q  <= '0;
            vld    <= '0;
        end else begin
            done   <= state == S_FIN;
            busy_q <= state == S_IDLE ? 1'b0 : busy_now;
            if (state == S_IDLE && start) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
                pf_q <= op_pf;
                sv_q <= sv;
            end
            if (state == S_EXEC) begin
                res_q <= e != '0 ? '0 : r;
                err_q <= e;
                we_q  <= pf_q && op_q == 8'h01;
            end
            // A busy start also counts as an error, so it suppresses result and write.
            if (state == S_FIN) begin
                err    <= {err_q, busy_now};
                result <= (err_q != '0 || busy_now) ? '0 : res_q;
            end
            if (wr_ok) vld[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_ok) mem[idx] <= b_q;
    end
endmodule

// File: tb/tb_tiny_alu_ctrl_p.sv
// tb_tiny_alu_ctrl_p: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_tiny_alu_ctrl_p;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [7:0]  op = '0;
    logic        op_pf = 1'b0, sv = 1'b0, start = 1'b0;
    logic        done, gp;
    logic [63:0] result;
    logic [5:0]  err;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  e;
        int          st;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0, cyc = 0;

    tiny_alu_ctrl_p dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .op_pf(op_pf),
        .sv(sv), .start(start), .done(done), .result(result), .err(err), .gp(gp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("result", result, x.res);
                chk("err", {58'd0, err}, {58'd0, x.e});
                chk("gp", {63'd0, gp}, {63'd0, |x.e});
                chk("latency", 64'(cyc - x.st), 64'd3);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] o,
                         input logic p, input logic s, input logic [63:0] er,
                         input logic [5:0] ee, input int hold);
        @(negedge clk);
        A = a; B = b; op = o; op_pf = p; sv = s; start = 1'b1;
        sb.push_back('{er, ee, cyc + 1});
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
        A = $urandom; B = $urandom; op = 8'($urandom);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", 64'd1, 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_err", {58'd0, err}, 64'd0);
        chk("rst_gp", {63'd0, gp}, 64'd0);
        reset_n = 1'b1;

        issue(32'hFFFFFFFF, 32'h1,        8'h00, 0, 0, 64'h1_00000000, 6'h00, 1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h02, 0, 0, 64'hFFFFFFFE_00000001, 6'h00, 1);
        issue(32'h1,        32'h2,        8'h01, 0, 0, 64'h1_FFFFFFFF, 6'h00, 1);
        issue(32'h5,        32'h3,        8'h01, 0, 1, 64'h2, 6'h00, 1);
        issue(32'hF0F0,     32'hFF00,     8'h03, 0, 0, 64'hF000, 6'h00, 1);
        issue(32'hF0F0,     32'hFF00,     8'h04, 0, 0, 64'hFFF0, 6'h00, 1);
        issue(32'hF0F0,     32'hFF00,     8'h05, 0, 0, 64'h0FF0, 6'h00, 1);
        issue(32'h10,       32'hCAFE,     8'h01, 1, 0, 64'hCAFE, 6'h00, 1);
        issue(32'h10,       32'h0,        8'h00, 1, 0, 64'hCAFE, 6'h00, 1);
        issue(32'h11,       32'h0,        8'h00, 1, 0, 64'h0, 6'h08, 1);
        issue(32'hFFFFFF05, 32'h1234,     8'h01, 1, 0, 64'h0, 6'h02, 1);
        issue(32'hFFFFFF05, 32'h0,        8'h00, 1, 1, 64'h0, 6'h08, 1);
        issue(32'hFFFFFF05, 32'h1234,     8'h01, 1, 1, 64'h1234, 6'h00, 1);
        issue(32'hFFFFFF05, 32'h0,        8'h00, 1, 1, 64'h1234, 6'h00, 1);
        issue(32'hFFFFFF05, 32'h0,        8'h00, 1, 0, 64'h0, 6'h02, 1);
        issue(32'h05,       32'h0,        8'h00, 1, 1, 64'h0, 6'h08, 1);
        issue(32'h00001000, 32'h0,        8'h00, 1, 1, 64'h0, 6'h10, 1);
        issue(32'h00001000, 32'h77,       8'h01, 1, 1, 64'h0, 6'h20, 1);
        issue(32'h0,        32'h0,        8'h07, 0, 0, 64'h0, 6'h04, 1);
        issue(32'h0,        32'h0,        8'h02, 1, 1, 64'h0, 6'h04, 1);
        issue(32'h0,        32'h0,        8'h0A, 0, 0, 64'h0, 6'h02, 1);
        issue(32'h10,       32'hBEEF,     8'h01, 1, 0, 64'hBEEF, 6'h00, 1);
        issue(32'h10,       32'h0,        8'h00, 1, 0, 64'hBEEF, 6'h00, 1);
        issue(32'hFF,       32'h0,        8'h00, 1, 0, 64'h0, 6'h08, 1);
        issue(32'hFF,       32'h55AA,     8'h01, 1, 0, 64'h55AA, 6'h00, 1);
        issue(32'hFF,       32'h0,        8'h00, 1, 0, 64'h55AA, 6'h00, 1);
        issue(32'h100,      32'h0,        8'h00, 1, 0, 64'h0, 6'h10, 1);
        issue(32'h20,       32'h99,       8'h01, 1, 0, 64'h0, 6'h01, 4);
        issue(32'h20,       32'h0,        8'h00, 1, 0, 64'h0, 6'h08, 1);
        issue(32'h0,        32'h0,        8'h0A, 0, 1, 64'hDEADBEEF, 6'h00, 1);

        @(negedge clk);
        A = 32'h3; B = 32'h4; op = 8'h00; op_pf = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_err", {58'd0, err}, 64'd0);
        chk("midrst_gp", {63'd0, gp}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        issue(32'h10, 32'h0, 8'h00, 1, 0, 64'h0, 6'h08, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
